// File: rtl/as_pipe_acc_if.sv
// Operand/result bundle for the pipelined add/subtract accumulator.
// The master side issues operations and clears; the slave side is the unit.
interface as_pipe_acc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             o;
  logic             o_sticky;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, clr,
    input  out_valid, s, o, o_sticky, acc
  );

  modport slave (
    input  in_valid, op, a, b, clr,
    output out_valid, s, o, o_sticky, acc
  );
endinterface

// File: rtl/as_pipe_acc.sv
// Two-stage two's-complement add/subtract unit with an internal accumulator.
// Stage 1 captures the operation; stage 2 runs the add, flags signed overflow,
// optionally saturates, and updates the accumulator and sticky overflow flag.
// Op encoding: 00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A.
module as_pipe_acc #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input logic          clk,
  input logic          rst,
  as_pipe_acc_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic             v1;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             o_q;
  logic             sticky_q;
  logic [WIDTH-1:0] acc_q;

  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] yx;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] raw;
  logic             carry_into_msb;
  logic             carry_out;
  logic             ovf;
  logic [WIDTH-1:0] res;

  // Stage 1: capture the issued operation; operands hold while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      op1 <= '0;
      a1  <= '0;
      b1  <= '0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        op1 <= bus.op;
        a1  <= bus.a;
        b1  <= bus.b;
      end
    end
  end

  // Stage 2 datapath: X + (Y ^ sub) + sub, overflow from the MSB carries, optional clamp
  always_comb begin
    sub            = op1[0];
    x              = op1[1] ? acc_q : a1;
    y              = op1[1] ? a1 : b1;
    yx             = y ^ {WIDTH{sub}};
    sum_ext        = {1'b0, x} + {1'b0, yx} + {{WIDTH{1'b0}}, sub};
    raw            = sum_ext[MSB:0];
    carry_out      = sum_ext[WIDTH];
    carry_into_msb = raw[MSB] ^ x[MSB] ^ yx[MSB];
    ovf            = carry_into_msb ^ carry_out;
    res            = raw;
    if ((SAT != 0) && ovf) begin
      res = x[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
  end

  // Stage 2 registers: result, overflow, accumulator and sticky flag; clr wins over the update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      o_q         <= 1'b0;
      sticky_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= v1;
      if (v1) begin
        s_q <= res;
        o_q <= ovf;
      end
      if (bus.clr) begin
        acc_q    <= '0;
        sticky_q <= 1'b0;
      end else if (v1) begin
        acc_q    <= res;
        sticky_q <= sticky_q | ovf;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.o         = o_q;
  assign bus.o_sticky  = sticky_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_as_pipe_acc.sv
// Bench for as_pipe_acc: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// share one stimulus stream; a queue of issued ops is popped when results are due
// and checked against an integer-arithmetic reference model.
module tb_as_pipe_acc;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic       drv_valid;
  logic [1:0] drv_op;
  logic [7:0] drv_a;
  logic [7:0] drv_b;
  logic       drv_clr;

  as_pipe_acc_if #(.WIDTH(4)) bus0 ();
  as_pipe_acc_if #(.WIDTH(4)) bus1 ();
  as_pipe_acc_if #(.WIDTH(8)) bus2 ();

  assign bus0.in_valid = drv_valid;
  assign bus0.op       = drv_op;
  assign bus0.a        = drv_a[3:0];
  assign bus0.b        = drv_b[3:0];
  assign bus0.clr      = drv_clr;
  assign bus1.in_valid = drv_valid;
  assign bus1.op       = drv_op;
  assign bus1.a        = drv_a[3:0];
  assign bus1.b        = drv_b[3:0];
  assign bus1.clr      = drv_clr;
  assign bus2.in_valid = drv_valid;
  assign bus2.op       = drv_op;
  assign bus2.a        = drv_a;
  assign bus2.b        = drv_b;
  assign bus2.clr      = drv_clr;

  as_pipe_acc #(.WIDTH(4), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  as_pipe_acc #(.WIDTH(4), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  as_pipe_acc #(.WIDTH(8), .SAT(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic       obs_v[3];
  logic [7:0] obs_s[3];
  logic       obs_o[3];
  logic       obs_st[3];
  logic [7:0] obs_acc[3];

  assign obs_v[0]   = bus0.out_valid;
  assign obs_s[0]   = {4'b0, bus0.s};
  assign obs_o[0]   = bus0.o;
  assign obs_st[0]  = bus0.o_sticky;
  assign obs_acc[0] = {4'b0, bus0.acc};
  assign obs_v[1]   = bus1.out_valid;
  assign obs_s[1]   = {4'b0, bus1.s};
  assign obs_o[1]   = bus1.o;
  assign obs_st[1]  = bus1.o_sticky;
  assign obs_acc[1] = {4'b0, bus1.acc};
  assign obs_v[2]   = bus2.out_valid;
  assign obs_s[2]   = bus2.s;
  assign obs_o[2]   = bus2.o;
  assign obs_st[2]  = bus2.o_sticky;
  assign obs_acc[2] = bus2.acc;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         due;
  } rec_t;

  rec_t       sb[$];
  logic [7:0] m_acc[3];
  logic       m_st[3];
  int         cycle;
  int         compared;
  int         mismatched;

  function automatic int width_of(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic int sext(input logic [7:0] v, input int w);
    int r;
    r = int'(v) & ((1 << w) - 1);
    if (r >= (1 << (w - 1))) r = r - (1 << w);
    return r;
  endfunction

  // Reference: exact integer result, overflow when outside the signed range
  function automatic void calc(input int k, input logic [1:0] op, input logic [7:0] accv,
                               input logic [7:0] av, input logic [7:0] bv,
                               output logic [7:0] es, output logic eo);
    int w, x, y, r, mx, mn;
    w  = width_of(k);
    x  = op[1] ? sext(accv, w) : sext(av, w);
    y  = op[1] ? sext(av, w) : sext(bv, w);
    r  = op[0] ? (x - y) : (x + y);
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    eo = (r > mx) || (r < mn);
    if (eo && (k == 1)) r = (r > mx) ? mx : mn;
    es = 8'(r & ((1 << w) - 1));
  endfunction

  task automatic checkOutput(input string tag, input int k, input logic [7:0] obs,
                             input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s dut%0d cycle %0d observed=%0h expected=%0h", tag, k, cycle, obs, exp);
    end
  endtask

  // Advance one edge, then compare every instance against the model
  task automatic tick();
    logic       clr_edge;
    rec_t       r;
    logic [7:0] es;
    logic       eo;
    bit         due_now;
    clr_edge = drv_clr;
    @(posedge clk);
    #1;
    cycle++;
    due_now = (sb.size() > 0) && (sb[0].due == cycle);
    if (due_now) begin
      r = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        calc(k, r.op, m_acc[k], r.a, r.b, es, eo);
        checkOutput("out_valid", k, {7'b0, obs_v[k]}, 8'd1);
        checkOutput("s", k, obs_s[k], es);
        checkOutput("o", k, {7'b0, obs_o[k]}, {7'b0, eo});
        m_acc[k] = clr_edge ? 8'd0 : es;
        m_st[k]  = clr_edge ? 1'b0 : (m_st[k] | eo);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("out_valid_idle", k, {7'b0, obs_v[k]}, 8'd0);
        if (clr_edge) begin
          m_acc[k] = 8'd0;
          m_st[k]  = 1'b0;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput("acc", k, obs_acc[k], m_acc[k]);
      checkOutput("o_sticky", k, {7'b0, obs_st[k]}, {7'b0, m_st[k]});
    end
  endtask

  // Drive one cycle of stimulus and record issued ops with their due cycle
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic c);
    rec_t r;
    drv_valid = v;
    drv_op    = op;
    drv_a     = a;
    drv_b     = b;
    drv_clr   = c;
    if (v) begin
      r.op  = op;
      r.a   = a;
      r.b   = b;
      r.due = cycle + 2;
      sb.push_back(r);
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput({tag, "_valid"}, k, {7'b0, obs_v[k]}, 8'd0);
      checkOutput({tag, "_s"}, k, obs_s[k], 8'd0);
      checkOutput({tag, "_o"}, k, {7'b0, obs_o[k]}, 8'd0);
      checkOutput({tag, "_sticky"}, k, {7'b0, obs_st[k]}, 8'd0);
      checkOutput({tag, "_acc"}, k, obs_acc[k], 8'd0);
    end
  endtask

  // Assert reset between edges, check outputs clear at once, release after one edge
  task automatic reset_mid();
    drv_valid = 1'b0;
    drv_clr   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 8'd0;
      m_st[k]  = 1'b0;
    end
    @(posedge clk);
    #1;
    cycle++;
    check_all_zero("rst_hold");
    #2;
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cycle      = 0;
    rst        = 1'b1;
    drv_valid  = 1'b0;
    drv_op     = 2'b00;
    drv_a      = 8'd0;
    drv_b      = 8'd0;
    drv_clr    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 8'd0;
      m_st[k]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #1;
    rst = 1'b0;

    $display("[TB] positive overflow 7+1");
    applyStimulus(1'b1, 2'b00, 8'd7, 8'd1, 1'b0);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    checkOutput("wrap_7p1_s", 0, obs_s[0], 8'h08);
    checkOutput("wrap_7p1_o", 0, {7'b0, obs_o[0]}, 8'd1);
    checkOutput("wrap_7p1_acc", 0, obs_acc[0], 8'h08);
    checkOutput("sat_7p1_s", 1, obs_s[1], 8'h07);
    checkOutput("sat_7p1_o", 1, {7'b0, obs_o[1]}, 8'd1);

    $display("[TB] negative overflow -8-1");
    applyStimulus(1'b1, 2'b01, 8'hF8, 8'd1, 1'b0);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    checkOutput("sat_m8m1_s", 1, obs_s[1], 8'h08);
    checkOutput("sat_m8m1_o", 1, {7'b0, obs_o[1]}, 8'd1);
    checkOutput("wrap_m8m1_s", 0, obs_s[0], 8'h07);

    $display("[TB] boundaries");
    applyStimulus(1'b1, 2'b01, 8'd0, 8'h80, 1'b0);
    applyStimulus(1'b1, 2'b01, 8'd37, 8'd37, 1'b0);
    checkOutput("zero_minus_min_o", 2, {7'b0, obs_o[2]}, 8'd1);
    applyStimulus(1'b1, 2'b00, 8'hFF, 8'h01, 1'b0);
    checkOutput("equal_sub_s", 2, obs_s[2], 8'd0);
    checkOutput("equal_sub_o", 2, {7'b0, obs_o[2]}, 8'd0);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b1);
    checkOutput("carry_no_ovf_s", 2, obs_s[2], 8'd0);
    checkOutput("carry_no_ovf_o", 2, {7'b0, obs_o[2]}, 8'd0);

    $display("[TB] back-to-back chain");
    applyStimulus(1'b1, 2'b00, 8'd10, 8'd5, 1'b0);
    applyStimulus(1'b1, 2'b10, 8'd3, 8'd0, 1'b0);
    checkOutput("chain_s0", 2, obs_s[2], 8'd15);
    applyStimulus(1'b1, 2'b11, 8'd20, 8'd0, 1'b0);
    checkOutput("chain_s1", 2, obs_s[2], 8'd18);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    checkOutput("chain_s2", 2, obs_s[2], 8'hFE);
    checkOutput("chain_acc", 2, obs_acc[2], 8'hFE);
    checkOutput("chain_o", 2, {7'b0, obs_o[2]}, 8'd0);

    $display("[TB] clr coinciding with stage-2 op");
    applyStimulus(1'b1, 2'b00, 8'd100, 8'd100, 1'b0);
    applyStimulus(1'b1, 2'b00, 8'd50, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    checkOutput("pre_clr_acc", 2, obs_acc[2], 8'd50);
    checkOutput("pre_clr_sticky", 2, {7'b0, obs_st[2]}, 8'd1);
    applyStimulus(1'b1, 2'b10, 8'd1, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b1);
    checkOutput("clr_op_s", 2, obs_s[2], 8'd51);
    checkOutput("clr_op_valid", 2, {7'b0, obs_v[2]}, 8'd1);
    checkOutput("clr_op_acc", 2, obs_acc[2], 8'd0);
    checkOutput("clr_op_sticky", 2, {7'b0, obs_st[2]}, 8'd0);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);

    $display("[TB] async reset with ops in flight");
    applyStimulus(1'b1, 2'b00, 8'd3, 8'd4, 1'b0);
    applyStimulus(1'b1, 2'b00, 8'd5, 8'd6, 1'b0);
    reset_mid();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 2'b00, 8'd2, 8'd3, 1'b0);
    checkOutput("post_rst_not_early", 2, {7'b0, obs_v[2]}, 8'd0);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    checkOutput("post_rst_s", 2, obs_s[2], 8'd5);

    $display("[TB] exhaustive 4-bit sweep");
    for (int op = 0; op < 4; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          if ($urandom_range(0, 7) == 0) applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
          applyStimulus(1'b1, 2'(op), {4'($urandom_range(0, 15)), 4'(a)},
                        {4'($urandom_range(0, 15)), 4'(b)}, ($urandom_range(0, 31) == 0));
        end
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    checkOutput("drained", 0, 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
